// File: rtl/fp_regfile_scoreboard.sv
// FP register file with 3 read ports and 2 write ports.
// Has a busy scoreboard for long-latency ops and a post-reset clear sweep.
module fp_regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iClear,
  output logic              oReady,
  input  logic [ADDR_W-1:0] iRA1,
  input  logic [ADDR_W-1:0] iRA2,
  input  logic [ADDR_W-1:0] iRA3,
  output logic [DATA_W-1:0] oRD1,
  output logic [DATA_W-1:0] oRD2,
  output logic [DATA_W-1:0] oRD3,
  output logic              oBusy1,
  output logic              oBusy2,
  output logic              oBusy3,
  output logic              oBusyAny,
  input  logic              iWeA,
  input  logic [ADDR_W-1:0] iWaA,
  input  logic [DATA_W-1:0] iWdA,
  input  logic              iWeB,
  input  logic [ADDR_W-1:0] iWaB,
  input  logic [DATA_W-1:0] iWdB,
  input  logic              iIssue,
  input  logic [ADDR_W-1:0] iIssueReg,
  output logic              oWawErr,
  input  logic [ADDR_W-1:0] iRegDispSelect,
  output logic [DATA_W-1:0] oRegDisp,
  input  logic [ADDR_W-1:0] iVGASelect,
  output logic [DATA_W-1:0] oVGARead
);

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_n;
  logic              run;
  logic              we_a;
  logic              we_b;
  logic [ADDR_W-1:0] ra [3];
  logic [DATA_W-1:0] rd [3];
  logic              bz [3];

  assign run  = (state == S_RUN);
  assign we_a = run & iWeA;
  assign we_b = run & iWeB;

  assign ra[0] = iRA1;
  assign ra[1] = iRA2;
  assign ra[2] = iRA3;

  // State and sweep-counter register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (!run)
        cnt <= cnt + 1'b1;
      else if (iClear)
        cnt <= '0;
    end
  end

  // Next state: sweep ends on the last register, iClear restarts it
  always_comb begin
    state_n = state;
    unique case (state)
      S_CLEAR: if (cnt == LAST) state_n = S_RUN;
      S_RUN:   if (iClear) state_n = S_CLEAR;
      default: state_n = S_CLEAR;
    endcase
  end

  // Storage has no reset so it can map to RAM; sweep zeroes it
  always_ff @(posedge iCLK) begin
    if (!run) begin
      mem[cnt] <= '0;
    end else begin
      if (we_b) mem[iWaB] <= iWdB;
      if (we_a) mem[iWaA] <= iWdA;
    end
  end

  // Busy update: B completion clears, a newer issue sets
  always_comb begin
    busy_n = busy;
    if (we_b)   busy_n[iWaB]      = 1'b0;
    if (iIssue) busy_n[iIssueReg] = 1'b1;
  end

  // Busy register, wiped when a clear sweep starts
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)
      busy <= '0;
    else if (run)
      busy <= iClear ? '0 : busy_n;
  end

  // One-cycle pulse when both write ports hit one address
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)
      oWawErr <= 1'b0;
    else
      oWawErr <= we_a & we_b & (iWaA == iWaB);
  end

  // Read ports with optional write-first forwarding, A over B
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rd[i] = '0;
      bz[i] = 1'b0;
      if (run) begin
        bz[i] = busy[ra[i]];
        if (BYPASS && we_a && ra[i] == iWaA)
          rd[i] = iWdA;
        else if (BYPASS && we_b && ra[i] == iWaB)
          rd[i] = iWdB;
        else
          rd[i] = mem[ra[i]];
      end
    end
  end

  assign oRD1     = rd[0];
  assign oRD2     = rd[1];
  assign oRD3     = rd[2];
  assign oBusy1   = bz[0];
  assign oBusy2   = bz[1];
  assign oBusy3   = bz[2];
  assign oBusyAny = |busy;
  assign oReady   = run;
  assign oRegDisp = run ? mem[iRegDispSelect] : '0;
  assign oVGARead = run ? mem[iVGASelect] : '0;

endmodule
